// File: rtl/tbuf_bus_pkg.sv
// rtl/tbuf_bus_pkg.sv - shared types and constants for the tristate bus arbiter
//
// Purpose: FSM state encoding, target NONE encoding, index-width helper and
//          default timing constants used by tbuf_bus_arbiter and rr_pick.
// Ports:   none (package).

package tbuf_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } state_e;

  // A latched target carries a "some" flag; this value of the flag means NONE.
  localparam logic TGT_NONE = 1'b0;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_TURN_CYC   = 1;
  localparam int DEF_MAX_TENURE = 16;

  // Width of an index able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: picks the first requester at or after (rr+1) mod NREQ, wrapping,
//          ignoring any bit set in mask.
// Ports:
//   req   in  NREQ  request vector
//   mask  in  NREQ  requesters excluded from this pick
//   rr    in  IW    round-robin pointer (last owner)
//   idx   out IW    winning index (0 when valid=0)
//   valid out 1     some unmasked requester was found

module rr_pick
  import tbuf_bus_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   rr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [NREQ-1:0] cand;
  int              pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    cand  = req & ~mask;
    // i runs 1..NREQ so the pointer's own slot is checked last.
    for (int i = 1; i <= NREQ; i++) begin
      pos = (int'(rr) + i) % NREQ;
      if (!valid && cand[pos[IW-1:0]]) begin
        valid = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// rtl/tbuf_bus_arbiter.sv - EN-line controller for a shared tristate bus
//
// Purpose: round-robin arbitration among NREQ tristate drivers with a tenure
//          limit and guaranteed all-off turnaround between owners; drives a
//          keeper driver while the bus is idle. All outputs are registered.
// Ports:
//   CLK     in  1     rising-edge clock
//   R       in  1     asynchronous active-low reset
//   req     in  NREQ  level requests
//   en      out NREQ  tristate enables (one-hot or zero)
//   gnt     out NREQ  grant, identical to en
//   dflt_en out 1     keeper driver enable, exclusive with en
//   owner   out IW    current owner index, valid while busy
//   busy    out 1     a requester owns the bus

module tbuf_bus_arbiter
  import tbuf_bus_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int TURN_CYC   = DEF_TURN_CYC,
  parameter int MAX_TENURE = DEF_MAX_TENURE
) (
  input  logic                       CLK,
  input  logic                       R,
  input  logic [NREQ-1:0]            req,
  output logic [NREQ-1:0]            en,
  output logic [NREQ-1:0]            gnt,
  output logic                       dflt_en,
  output logic [idx_width(NREQ)-1:0] owner,
  output logic                       busy
);

  localparam int IW  = idx_width(NREQ);
  localparam int TW  = idx_width(TURN_CYC);
  localparam int TNW = idx_width(MAX_TENURE + 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   turn_q, turn_d;
  logic            gap_q, gap_d;
  logic [TNW-1:0]  ten_q, ten_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            tgt_some_q, tgt_some_d;
  logic [IW-1:0]   tgt_idx_q, tgt_idx_d;
  logic [NREQ-1:0] en_q, en_d;
  logic            dflt_q, dflt_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] pick_mask;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            own_leave;

  // rr_q always equals the current/last owner, so it doubles as owner.
  assign own_oh    = NREQ'(1) << rr_q;
  assign pick_mask = (state_q == ST_OWN) ? own_oh : '0;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .mask  (pick_mask),
    .rr    (rr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_leave = !req[rr_q] ||
                     ((MAX_TENURE != 0) && (ten_q == TNW'(MAX_TENURE)) &&
                      |(req & ~own_oh));

  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    gap_d      = gap_q;
    ten_d      = ten_q;
    rr_d       = rr_q;
    tgt_some_d = tgt_some_q;
    tgt_idx_d  = tgt_idx_q;
    en_d       = '0;
    dflt_d     = 1'b0;
    busy_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        dflt_d = 1'b1;
        if (|req) begin
          state_d    = ST_TURN;
          turn_d     = '0;
          // The keeper gets one extra off cycle before a requester drives,
          // giving it a full settle cycle after its own release.
          gap_d      = 1'b1;
          tgt_some_d = pick_valid;
          tgt_idx_d  = pick_idx;
          dflt_d     = 1'b0;
        end
      end

      ST_TURN: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (turn_q == TW'(TURN_CYC - 1)) begin
          turn_d = '0;
          if ((tgt_some_q != TGT_NONE) && req[tgt_idx_q]) begin
            state_d = ST_OWN;
            rr_d    = tgt_idx_q;
            ten_d   = (MAX_TENURE != 0) ? TNW'(1) : '0;
            en_d    = NREQ'(1) << tgt_idx_q;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            dflt_d  = 1'b1;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end

      ST_OWN: begin
        if (own_leave) begin
          state_d    = ST_TURN;
          turn_d     = '0;
          gap_d      = 1'b0;
          tgt_some_d = pick_valid;
          tgt_idx_d  = pick_idx;
        end else begin
          en_d   = own_oh;
          busy_d = 1'b1;
          if ((MAX_TENURE != 0) && (ten_q != TNW'(MAX_TENURE))) begin
            ten_d = ten_q + TNW'(1);
          end
        end
      end

      default: begin
        state_d = ST_TURN;
        turn_d  = '0;
        gap_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q    <= ST_TURN;
      turn_q     <= '0;
      gap_q      <= 1'b0;
      ten_q      <= '0;
      rr_q       <= '0;
      tgt_some_q <= TGT_NONE;
      tgt_idx_q  <= '0;
      en_q       <= '0;
      dflt_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      gap_q      <= gap_d;
      ten_q      <= ten_d;
      rr_q       <= rr_d;
      tgt_some_q <= tgt_some_d;
      tgt_idx_q  <= tgt_idx_d;
      en_q       <= en_d;
      dflt_q     <= dflt_d;
      busy_q     <= busy_d;
    end
  end

  assign en      = en_q;
  assign gnt     = en_q;
  assign dflt_en = dflt_q;
  assign busy    = busy_q;
  assign owner   = rr_q;

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// tb/tb_tbuf_bus_arbiter.sv - directed bench for tbuf_bus_arbiter

module tb_tbuf_bus_arbiter;

  logic       CLK;
  logic       R;
  logic [3:0] req_a, en_a, gnt_a;
  logic       dflt_a, busy_a;
  logic [1:0] owner_a;
  logic [3:0] req_b, en_b, gnt_b;
  logic       dflt_b, busy_b;
  logic [1:0] owner_b;

  int n_vec = 0;
  int n_bad = 0;

  tbuf_bus_arbiter #(.NREQ(4), .TURN_CYC(1), .MAX_TENURE(16)) dut_a (
    .CLK(CLK), .R(R), .req(req_a), .en(en_a), .gnt(gnt_a),
    .dflt_en(dflt_a), .owner(owner_a), .busy(busy_a)
  );

  tbuf_bus_arbiter #(.NREQ(4), .TURN_CYC(3), .MAX_TENURE(16)) dut_b (
    .CLK(CLK), .R(R), .req(req_b), .en(en_b), .gnt(gnt_b),
    .dflt_en(dflt_b), .owner(owner_b), .busy(busy_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int         seq[4] = '{1, 2, 3, 0};
  logic [3:0] prev_en;

  initial begin
    R = 1'b0; req_a = '0; req_b = '0;

    // Reset state and release.
    repeat (3) step();
    chk("rst_en",    en_a,    4'b0000);
    chk("rst_dflt",  dflt_a,  1'b0);
    chk("rst_busy",  busy_a,  1'b0);
    chk("rst_owner", owner_a, 2'd0);
    R = 1'b1;
    chk("rel_dflt0", dflt_a, 1'b0);
    step();
    chk("rel_dflt1", dflt_a, 1'b1);
    chk("rel_en",    en_a,   4'b0000);
    step();
    chk("idle_dflt", dflt_a, 1'b1);

    // Single grant from IDLE, latency and release.
    req_a = 4'b0100;
    step();
    chk("lat_dflt_k",  dflt_a, 1'b0);
    chk("lat_en_k",    en_a,   4'b0000);
    step();
    chk("lat_en_k1",   en_a,   4'b0000);
    step();
    chk("lat_en_k2",   en_a,   4'b0100);
    chk("lat_gnt_k2",  gnt_a,  4'b0100);
    chk("lat_owner",   owner_a, 2'd2);
    chk("lat_busy",    busy_a, 1'b1);
    chk("lat_dflt_k2", dflt_a, 1'b0);
    step();
    chk("hold_en", en_a, 4'b0100);
    req_a = 4'b0000;
    step();
    chk("drop_en",   en_a,   4'b0000);
    chk("drop_dflt", dflt_a, 1'b0);
    chk("drop_busy", busy_a, 1'b0);
    step();
    chk("drop_dflt1", dflt_a, 1'b1);
    chk("drop_en1",   en_a,   4'b0000);

    // Re-reset to clear rr, then rotate with everybody requesting.
    R = 1'b0;
    #2;
    chk("rr_rst_en", en_a, 4'b0000);
    R = 1'b1;
    step();
    chk("rr_idle", dflt_a, 1'b1);
    req_a = 4'b1111;
    step();
    chk("rr_k_dflt", dflt_a, 1'b0);
    step();
    chk("rr_k1_en", en_a, 4'b0000);
    foreach (seq[g]) begin
      for (int c = 0; c < 16; c++) begin
        step();
        chk($sformatf("rot_g%0d_c%0d", seq[g], c), en_a, 32'(4'b0001 << seq[g]));
      end
      step();
      chk($sformatf("rot_gap%0d", seq[g]), en_a, 4'b0000);
      chk($sformatf("rot_gapd%0d", seq[g]), dflt_a, 1'b0);
    end

    // Lone requester keeps the bus past tenure saturation.
    req_a = 4'b0001;
    step();
    chk("lone_idle", dflt_a, 1'b1);
    step();
    chk("lone_turn", dflt_a, 1'b0);
    step();
    step();
    chk("lone_grant", en_a, 4'b0001);
    for (int c = 0; c < 100; c++) begin
      step();
      chk("lone_hold", en_a, 4'b0001);
    end

    // Asynchronous reset while 0010 owns the bus.
    req_a = 4'b0000;
    step();
    chk("ar_rel", en_a, 4'b0000);
    step();
    chk("ar_idle", dflt_a, 1'b1);
    req_a = 4'b0010;
    repeat (3) step();
    chk("ar_own", en_a, 4'b0010);
    #3;
    R = 1'b0;
    #1;
    chk("ar_en0",   en_a,   4'b0000);
    chk("ar_gnt0",  gnt_a,  4'b0000);
    chk("ar_busy0", busy_a, 1'b0);
    chk("ar_dflt0", dflt_a, 1'b0);
    step();
    chk("ar_hold0", en_a, 4'b0000);
    R = 1'b1;
    step();
    chk("ar_re_idle", dflt_a, 1'b1);
    chk("ar_re_en",   en_a,   4'b0000);
    step();
    chk("ar_re_turn", dflt_a, 1'b0);
    step();
    step();
    chk("ar_re_own",   en_a,    4'b0010);
    chk("ar_re_owner", owner_a, 2'd1);

    // Random requests: driver exclusivity and turnaround on every cycle.
    prev_en = en_a;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req_a = 4'($urandom_range(0, 15));
      step();
      chk("inv_excl", 32'(($countones(en_a) + int'(dflt_a)) <= 1), 1);
      if (prev_en != 4'b0000 && en_a != 4'b0000)
        chk("inv_turn", en_a, prev_en);
      prev_en = en_a;
    end

    // TURN_CYC=3 instance: target drops during TURN, then a real grant.
    req_b = 4'b0010;
    step();
    chk("b_k_dflt", dflt_b, 1'b0);
    step();
    chk("b_k1_en", en_b, 4'b0000);
    req_b = 4'b0000;
    step();
    chk("b_k2_en", en_b, 4'b0000);
    step();
    chk("b_k3_en",   en_b,   4'b0000);
    chk("b_k3_dflt", dflt_b, 1'b0);
    step();
    chk("b_k4_en",   en_b,   4'b0000);
    chk("b_k4_dflt", dflt_b, 1'b1);
    step();
    chk("b_idle_en", en_b, 4'b0000);
    req_b = 4'b0010;
    step();
    chk("b_g_dflt", dflt_b, 1'b0);
    repeat (3) begin
      step();
      chk("b_g_wait", en_b, 4'b0000);
    end
    step();
    chk("b_g_en",    en_b,    4'b0010);
    chk("b_g_owner", owner_b, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
